// File: rtl/sha_digest_serializer.sv
// Captures parallel hash results into a small record queue and streams each one out as bytes.
// Define SHA_SER_HEADER_EN to prefix each digest with a 4-byte id and 8-byte length header.
module sha_digest_serializer #(
    parameter int DIGEST_BITS    = 224,
    parameter int FIFO_DEPTH_LOG = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   ivalid,
    input  logic [31:0]            iid,
    input  logic [60:0]            ilen,
    input  logic [DIGEST_BITS-1:0] isha,
    output logic                   ovalid,
    input  logic                   oready,
    output logic [7:0]             odata,
    output logic                   olast,
    output logic                   overflow
);

`ifdef SHA_SER_HEADER_EN
    localparam int HDR_BYTES = 12;
`else
    localparam int HDR_BYTES = 0;
`endif
    localparam int REC_BYTES = HDR_BYTES + DIGEST_BITS / 8;
    localparam int REC_BITS  = REC_BYTES * 8;
    localparam int CNT_W     = $clog2(REC_BYTES);
    localparam int DEPTH     = 1 << FIFO_DEPTH_LOG;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REC_BYTES - 1);

    typedef struct packed {
`ifdef SHA_SER_HEADER_EN
        logic [31:0]            id;
        logic [60:0]            len;
`endif
        logic [DIGEST_BITS-1:0] sha;
    } rec_t;

    typedef enum logic {IDLE, SEND} state_t;

    rec_t                    mem_q [DEPTH];
    rec_t                    in_rec;
    rec_t                    head_rec;
    logic [REC_BITS-1:0]     head_bits;
    logic [FIFO_DEPTH_LOG:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                    empty, full, push, pop;
    logic [REC_BITS-1:0]     sh_q, sh_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    state_t                  state_q, state_d;
    logic                    overflow_q, overflow_d;

    always_comb begin
        in_rec     = '0;
`ifdef SHA_SER_HEADER_EN
        in_rec.id  = iid;
        in_rec.len = ilen;
`endif
        in_rec.sha = isha;
    end

    assign head_rec = mem_q[rd_ptr_q[FIFO_DEPTH_LOG-1:0]];

`ifdef SHA_SER_HEADER_EN
    // Length is zero-extended to a 64-bit big-endian field.
    assign head_bits = {head_rec.id, 3'b000, head_rec.len, head_rec.sha};
`else
    assign head_bits = head_rec.sha;
    logic unused_hdr;
    assign unused_hdr = ^{iid, ilen};
`endif

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_DEPTH_LOG] != rd_ptr_q[FIFO_DEPTH_LOG]) &&
                   (wr_ptr_q[FIFO_DEPTH_LOG-1:0] == rd_ptr_q[FIFO_DEPTH_LOG-1:0]);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    sh_d    = head_bits;
                    cnt_d   = '0;
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (oready) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        // Chain straight into the next record so ovalid never bubbles.
                        if (!empty) begin
                            sh_d = head_bits;
                            pop  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sh_d  = {sh_q[REC_BITS-9:0], 8'h00};
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop on this edge frees a slot for a simultaneous write to a full queue.
        push       = ivalid && (!full || pop);
        overflow_d = overflow_q || (ivalid && full && !pop);
        wr_ptr_d   = wr_ptr_q + {{FIFO_DEPTH_LOG{1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{FIFO_DEPTH_LOG{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sh_q       <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[FIFO_DEPTH_LOG-1:0]] <= in_rec;
    end

    assign ovalid   = (state_q == SEND);
    assign odata    = sh_q[REC_BITS-1 -: 8];
    assign olast    = ovalid && (cnt_q == CNT_LAST);
    assign overflow = overflow_q;

endmodule
